// File: rtl/max7219_pkg.sv
// Shared constants, register map and FSM state type for the MAX7219 chain transmitter.
package max7219_pkg;

  localparam int unsigned C_MAX7219_WORD_W = 16;

  // MAX7219 register addresses (bits [11:8] of each 16-bit word)
  localparam logic [3:0] C_REG_NOOP         = 4'h0;
  localparam logic [3:0] C_REG_DIGIT0       = 4'h1;
  localparam logic [3:0] C_REG_DIGIT1       = 4'h2;
  localparam logic [3:0] C_REG_DIGIT2       = 4'h3;
  localparam logic [3:0] C_REG_DIGIT3       = 4'h4;
  localparam logic [3:0] C_REG_DIGIT4       = 4'h5;
  localparam logic [3:0] C_REG_DIGIT5       = 4'h6;
  localparam logic [3:0] C_REG_DIGIT6       = 4'h7;
  localparam logic [3:0] C_REG_DIGIT7       = 4'h8;
  localparam logic [3:0] C_REG_DECODE_MODE  = 4'h9;
  localparam logic [3:0] C_REG_INTENSITY    = 4'hA;
  localparam logic [3:0] C_REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] C_REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] C_REG_DISPLAY_TEST = 4'hF;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, LATCH} max7219_tx_state_t;

  // Build one device word from a register address and a data byte
  function automatic logic [C_MAX7219_WORD_W-1:0] max7219_word(input logic [3:0] addr,
                                                               input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_sclk_div.sv
// Half-period tick generator: o_tick is high on every G_CLK_DIV-th cycle after a clear.
module max7219_sclk_div #(
  parameter int unsigned G_CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(G_CLK_DIV + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign o_tick = (cnt_q == CntW'(G_CLK_DIV - 1));

  // Count 0..G_CLK_DIV-1 and wrap; clear holds the count at zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/max7219_chain_tx.sv
// Serial frame transmitter for a daisy chain of MAX7219 drivers (CLK/DIN/LOAD).
module max7219_chain_tx #(
  parameter int unsigned G_MATRIX_NB   = 2,
  parameter int unsigned G_CLK_DIV     = 4,
  parameter int unsigned G_LOAD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [16*G_MATRIX_NB-1:0] i_data,
  output logic                      o_ready,
  output logic                      o_done,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load
);

  import max7219_pkg::*;

  localparam int unsigned N        = C_MAX7219_WORD_W * G_MATRIX_NB;
  localparam int unsigned BitCntW  = $clog2(N + 1);
  localparam int unsigned LoadCntW = $clog2(G_LOAD_CYCLES + 1);

  max7219_tx_state_t   state_d, state_q;
  logic [N-1:0]        sh_d, sh_q;
  logic [BitCntW-1:0]  bit_cnt_d, bit_cnt_q;
  logic [LoadCntW-1:0] load_cnt_d, load_cnt_q;
  logic                ready_d, ready_q;
  logic                done_d, done_q;
  logic                sclk_d, sclk_q;
  logic                din_d, din_q;
  logic                load_d, load_q;
  logic                tick;

  // Divider is held cleared in IDLE so the first LOW phase is a full half-period
  max7219_sclk_div #(
    .G_CLK_DIV (G_CLK_DIV)
  ) u_sclk_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (state_q == IDLE),
    .o_tick (tick)
  );

  // Next-state and next-output logic; outputs hold unless a transition changes them
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    load_cnt_d = load_cnt_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    din_d      = din_q;
    load_d     = load_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = LOW;
          sh_d      = i_data;
          bit_cnt_d = BitCntW'(N);
          ready_d   = 1'b0;
          load_d    = 1'b0;
          din_d     = i_data[N-1];
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_q == BitCntW'(1)) begin
            state_d = TAIL;
            din_d   = 1'b0;
          end else begin
            state_d = LOW;
            sh_d    = sh_q << 1;
            din_d   = sh_q[N-2];
          end
        end
      end
      TAIL: begin
        if (tick) begin
          state_d    = LATCH;
          load_d     = 1'b1;
          load_cnt_d = '0;
        end
      end
      LATCH: begin
        if (load_cnt_q == LoadCntW'(G_LOAD_CYCLES - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        load_d  = 1'b1;
      end
    endcase
  end

  // FSM state, datapath and registered outputs; reset returns to idle pin levels
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      load_cnt_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      din_q      <= 1'b0;
      load_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      load_cnt_q <= load_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
      load_q     <= load_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_done         = done_q;
  assign o_max7219_clk  = sclk_q;
  assign o_max7219_din  = din_q;
  assign o_max7219_load = load_q;

endmodule

// File: tb/tb_max7219_chain_tx.sv
// Self-checking bench for max7219_chain_tx with a MAX7219 chain emulator on the pins.
module tb_max7219_chain_tx;

  localparam int unsigned NB = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned L  = 2;
  localparam int unsigned N  = 16 * NB;
  localparam int unsigned BUSY = 2 * N * D + D + L;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [N-1:0] i_data = '0;
  logic         o_ready, o_done, o_max7219_clk, o_max7219_din, o_max7219_load;

  max7219_chain_tx #(
    .G_MATRIX_NB   (NB),
    .G_CLK_DIV     (D),
    .G_LOAD_CYCLES (L)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_done         (o_done),
    .o_max7219_clk  (o_max7219_clk),
    .o_max7219_din  (o_max7219_din),
    .o_max7219_load (o_max7219_load)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain emulator and pin monitor, sampled on the falling edge
  logic [N-1:0] emu_sr = '0;
  logic [7:0]   emu_reg [NB][16];
  logic         p_clk = 1'b0, p_din = 1'b0, p_load = 1'b1;
  int unsigned  din_stable = 0, rises = 0, load_rises = 0, done_cnt = 0, tim_bad = 0;
  int unsigned  last_fall_cyc = 0, last_load_rise_cyc = 0, load_high_len = 0;

  always @(negedge clk) begin : mon
    int unsigned stab;
    int unsigned bad;
    bad  = 0;
    stab = (o_max7219_din == p_din) ? din_stable + 1 : 0;
    din_stable <= stab;
    if (o_max7219_clk && !p_clk) begin
      rises  <= rises + 1;
      emu_sr <= {emu_sr[N-2:0], o_max7219_din};
      if (stab < D || o_max7219_load) bad++;
    end
    if (o_max7219_clk && p_clk && (o_max7219_din != p_din)) bad++;
    if (!o_max7219_clk && p_clk) last_fall_cyc <= cyc;
    if (o_max7219_load && !p_load && !rst) begin
      load_rises         <= load_rises + 1;
      last_load_rise_cyc <= cyc;
      if (cyc - last_fall_cyc != D) bad++;
      for (int k = 0; k < NB; k++) emu_reg[k][emu_sr[16*k+8 +: 4]] <= emu_sr[16*k +: 8];
    end
    if (!o_max7219_load && p_load) load_high_len <= cyc - last_load_rise_cyc;
    if (o_done) done_cnt <= done_cnt + 1;
    tim_bad <= tim_bad + bad;
    p_clk  <= o_max7219_clk;
    p_din  <= o_max7219_din;
    p_load <= o_max7219_load;
  end

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned acc = 0, r0 = 0, l0 = 0, d0 = 0, t0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    r0 = rises; l0 = load_rises; d0 = done_cnt; t0 = tim_bad;
  endtask

  // Present a frame for one accepting edge and check the first wire state
  task automatic start_frame(input logic [N-1:0] data, input string tag);
    @(negedge clk); #1;
    snap();
    i_data  = data;
    i_start = 1'b1;
    @(negedge clk); #1;
    i_start = 1'b0;
    acc = cyc;
    chk({tag, ".ready_low"}, o_ready, 0);
    chk({tag, ".load_low"}, o_max7219_load, 0);
    chk({tag, ".first_din"}, o_max7219_din, data[N-1]);
  endtask

  // Wait for o_done and check the whole frame against the reference
  task automatic finish_frame(input logic [N-1:0] data, input int pulse_at,
                              input logic [N-1:0] pdata, input bit chain,
                              input logic [N-1:0] cdata, input string tag);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 2000) begin
      @(negedge clk); #1;
      k++;
      if (pulse_at > 0 && k == pulse_at) begin
        i_start = 1'b1;
        i_data  = pdata;
      end else if (pulse_at > 0 && k == pulse_at + 1) begin
        i_start = 1'b0;
      end
      if (o_done === 1'b1) seen = 1;
    end
    chk({tag, ".done_seen"}, seen, 1);
    if (chain) begin
      i_start = 1'b1;
      i_data  = cdata;
    end
    chk({tag, ".busy_cycles"}, cyc - acc, BUSY);
    chk({tag, ".ready_at_done"}, o_ready, 1);
    chk({tag, ".clk_rises"}, rises - r0, N);
    chk({tag, ".din_stream"}, emu_sr, data);
    chk({tag, ".load_rises"}, load_rises - l0, 1);
    chk({tag, ".done_pulses"}, done_cnt - d0, 1);
    chk({tag, ".timing_violations"}, tim_bad - t0, 0);
    for (int d = 0; d < NB; d++) begin
      chk($sformatf("%s.dev%0d_reg", tag, d), emu_reg[d][data[16*d+8 +: 4]], data[16*d +: 8]);
    end
    @(negedge clk); #1;
    if (chain) begin
      i_start = 1'b0;
      acc = cyc;
      snap();
      chk({tag, ".chain_load_fell"}, o_max7219_load, 0);
      chk({tag, ".load_high_len"}, load_high_len, L + 1);
      chk({tag, ".chain_first_din"}, o_max7219_din, cdata[N-1]);
    end else begin
      chk({tag, ".done_one_cycle"}, o_done, 0);
    end
  endtask

  typedef struct {
    logic [N-1:0] data;
    logic [3:0]   a1;
    logic [7:0]   v1;
    logic [3:0]   a0;
    logic [7:0]   v0;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [N-1:0] rnd;
    int           k;

    vecs[0] = '{32'h0C01_0A05, 4'hC, 8'h01, 4'hA, 8'h05};
    vecs[1] = '{32'h0101_0180, 4'h1, 8'h01, 4'h1, 8'h80};
    vecs[2] = '{32'h0B07_0902, 4'hB, 8'h07, 4'h9, 8'h02};
    vecs[3] = '{32'h0F00_08AA, 4'hF, 8'h00, 4'h8, 8'hAA};

    // Reset hold and idle behaviour
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("reset.ready", o_ready, 1);
    chk("reset.load", o_max7219_load, 1);
    chk("reset.clk", o_max7219_clk, 0);
    chk("reset.din", o_max7219_din, 0);
    chk("reset.done", o_done, 0);
    snap();
    repeat (20) @(negedge clk);
    #1;
    chk("idle.no_clk_edges", rises - r0, 0);
    chk("idle.load_high", o_max7219_load, 1);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i].data, $sformatf("vec%0d", i));
      finish_frame(vecs[i].data, 0, '0, 1'b0, '0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.dev1_expect", i), emu_reg[1][vecs[i].a1], vecs[i].v1);
      chk($sformatf("vec%0d.dev0_expect", i), emu_reg[0][vecs[i].a0], vecs[i].v0);
    end

    // Start request while busy is ignored
    start_frame(32'h0C01_0A05, "busy_start");
    finish_frame(32'h0C01_0A05, 50, 32'h0B0F_0B0F, 1'b0, '0, "busy_start");
    snap();
    repeat (20) @(negedge clk);
    #1;
    chk("busy_start.no_extra_done", done_cnt - d0, 0);
    chk("busy_start.no_extra_clk", rises - r0, 0);

    // Back-to-back: start in the done cycle
    start_frame(32'h0C01_0A05, "b2b_first");
    finish_frame(32'h0C01_0A05, 0, '0, 1'b1, 32'h0101_0180, "b2b_first");
    finish_frame(32'h0101_0180, 0, '0, 1'b0, '0, "b2b_second");
    chk("b2b.dev1_digit0", emu_reg[1][4'h1], 8'h01);
    chk("b2b.dev0_digit0", emu_reg[0][4'h1], 8'h80);

    // Reset mid-frame at bit 10
    start_frame(32'h0A0F_0A0E, "midreset");
    k = 0;
    while ((rises - r0) < 10 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("midreset.reached_bit10", rises - r0, 10);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midreset.ready", o_ready, 1);
    chk("midreset.load", o_max7219_load, 1);
    chk("midreset.clk", o_max7219_clk, 0);
    chk("midreset.din", o_max7219_din, 0);
    chk("midreset.done", o_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    chk("midreset.no_done", done_cnt - d0, 0);
    start_frame(32'h0C01_0A07, "after_reset");
    finish_frame(32'h0C01_0A07, 0, '0, 1'b0, '0, "after_reset");

    // Randomized frames checked against per-device address/data extraction
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < NB; d++) begin
        rnd[16*d +: 16] = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom)};
      end
      start_frame(rnd, $sformatf("rand%0d", i));
      finish_frame(rnd, 0, '0, 1'b0, '0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
